adc_chan_seq: RTL and testbench

ADC_CHAN_SEQ -- requirements
Module: adc_chan_seq

---
 rtl/adc_chan_seq_if.sv | 23 ++
 rtl/adc_chan_seq.sv | 155 +++++++++++++++
 tb/tb_adc_chan_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_chan_seq_if.sv
// Sample input and averaged-result handshake bundle for the ADC channel sequencer.
// The master modport is the sequencer side; the slave modport is the ADC/consumer side.
interface adc_chan_seq_if #(
  parameter int AD_DATA_NBIT = 12,
  parameter int CHAN_NBIT    = 2
);
  logic                    i_strobe;
  logic [AD_DATA_NBIT-1:0] i_inst_data;
  logic                    o_valid;
  logic                    i_ready;
  logic [CHAN_NBIT-1:0]    o_chan;
  logic [AD_DATA_NBIT-1:0] o_avg_data;

  modport master (
    input  i_strobe, i_inst_data, i_ready,
    output o_valid, o_chan, o_avg_data
  );

  modport slave (
    output i_strobe, i_inst_data, i_ready,
    input  o_valid, o_chan, o_avg_data
  );
endinterface

// File: rtl/adc_chan_seq.sv
// Round-robin ADC channel sequencer: selects a masked channel, waits for the mux to
// settle, averages 2**AD_AVG_NUM_NBIT samples and hands the result downstream.
module adc_chan_seq #(
  parameter int AD_DATA_NBIT    = 12,
  parameter int AD_AVG_NUM_NBIT = 3,
  parameter int CHAN_NBIT       = 2,
  parameter int SETTLE_CYC      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [(1<<CHAN_NBIT)-1:0]   i_chan_mask,
  output logic [CHAN_NBIT-1:0]        o_mux_sel,
  output logic                        o_busy,
  adc_chan_seq_if.master              bus
);

  localparam int NCH      = 1 << CHAN_NBIT;
  localparam int NSAMP    = 1 << AD_AVG_NUM_NBIT;
  localparam int SUM_NBIT = AD_DATA_NBIT + AD_AVG_NUM_NBIT;

  localparam logic [7:0]               SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [AD_AVG_NUM_NBIT:0] SAMP_LAST   = (AD_AVG_NUM_NBIT + 1)'(NSAMP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t                   state_r;
  logic [CHAN_NBIT-1:0]     ptr_r;
  logic [CHAN_NBIT-1:0]     mux_sel_r;
  logic                     busy_r;
  logic                     valid_r;
  logic [CHAN_NBIT-1:0]     chan_r;
  logic [AD_DATA_NBIT-1:0]  avg_r;
  logic [SUM_NBIT-1:0]      sum_r;
  logic [7:0]               settle_cnt_r;
  logic [AD_AVG_NUM_NBIT:0] samp_cnt_r;

  logic [CHAN_NBIT-1:0]     sel_chan_s;
  logic [SUM_NBIT-1:0]      acc_sum_s;
  logic                     last_samp_s;

  // First enabled channel at or after start, wrapping; start is returned if none is set.
  function automatic logic [CHAN_NBIT-1:0] next_chan(
    input logic [NCH-1:0]       mask,
    input logic [CHAN_NBIT-1:0] start
  );
    logic [CHAN_NBIT-1:0] idx;
    logic                 found;
    next_chan = start;
    found     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = start + CHAN_NBIT'(i);
      if (!found && mask[idx]) begin
        next_chan = idx;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Next-channel pick and running-sum arithmetic for the current sample.
  always_comb begin
    sel_chan_s  = next_chan(i_chan_mask, ptr_r);
    last_samp_s = (samp_cnt_r == SAMP_LAST);
    if (samp_cnt_r == '0) begin
      acc_sum_s = SUM_NBIT'(bus.i_inst_data);
    end else begin
      acc_sum_s = sum_r + SUM_NBIT'(bus.i_inst_data);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      mux_sel_r    <= '0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      chan_r       <= '0;
      avg_r        <= '0;
      sum_r        <= '0;
      settle_cnt_r <= '0;
      samp_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_enable && (i_chan_mask != '0)) begin
            state_r <= SELECT;
            busy_r  <= 1'b1;
          end
        end
        SELECT: begin
          if (!i_enable || (i_chan_mask == '0)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            mux_sel_r    <= sel_chan_s;
            settle_cnt_r <= '0;
            samp_cnt_r   <= '0;
            state_r      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ACCUM;
          end else begin
            settle_cnt_r <= settle_cnt_r + 8'd1;
          end
        end
        ACCUM: begin
          if (bus.i_strobe) begin
            sum_r <= acc_sum_s;
            if (last_samp_s) begin
              avg_r      <= AD_DATA_NBIT'(acc_sum_s >> AD_AVG_NUM_NBIT);
              chan_r     <= mux_sel_r;
              valid_r    <= 1'b1;
              samp_cnt_r <= '0;
              state_r    <= OUTPUT;
            end else begin
              samp_cnt_r <= samp_cnt_r + (AD_AVG_NUM_NBIT + 1)'(1'b1);
            end
          end
        end
        OUTPUT: begin
          // Pointer advances past the channel just delivered so the scan is fair.
          if (bus.i_ready) begin
            valid_r <= 1'b0;
            ptr_r   <= mux_sel_r + CHAN_NBIT'(1'b1);
            state_r <= SELECT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_mux_sel      = mux_sel_r;
  assign o_busy         = busy_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_chan     = chan_r;
  assign bus.o_avg_data = avg_r;

endmodule

// File: tb/tb_adc_chan_seq.sv
// Scoreboard bench for adc_chan_seq: directed scans push expected results, a negedge
// monitor pops and compares on every handshake and also checks hold, reset and idle.
module tb_adc_chan_seq;

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  mask = 4'b0000;
  logic [1:0]  mux_sel;
  logic        busy;

  adc_chan_seq_if #(.AD_DATA_NBIT(12), .CHAN_NBIT(2)) bus ();

  adc_chan_seq #(
    .AD_DATA_NBIT(12), .AD_AVG_NUM_NBIT(3), .CHAN_NBIT(2), .SETTLE_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_chan_mask(mask),
    .o_mux_sel(mux_sel), .o_busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Requests from the stimulus process to the monitor.
  int   gen_mode = 0;
  int   to_cnt = 0;
  bit   busy_chk = 1'b0;
  bit   busy_exp = 1'b0;
  bit   fin_req = 1'b0;

  // Strobe generator: 1 = every 4th cycle 100*(mux+1); 2 = 18x4095 then 0..7; 3 = 4095 every cycle.
  int drv_cyc = 0;
  int drv_prev = 0;
  always @(negedge clk) begin
    if (gen_mode != drv_prev) drv_cyc = 0;
    else drv_cyc = drv_cyc + 1;
    drv_prev = gen_mode;
    bus.i_strobe    = 1'b0;
    bus.i_inst_data = 12'd0;
    case (gen_mode)
      1: if (drv_cyc % 4 == 0) begin
           bus.i_strobe    = 1'b1;
           bus.i_inst_data = 12'(100 * (int'(mux_sel) + 1));
         end
      2: if (drv_cyc < 18) begin
           bus.i_strobe    = 1'b1;
           bus.i_inst_data = 12'd4095;
         end else if (drv_cyc < 26) begin
           bus.i_strobe    = 1'b1;
           bus.i_inst_data = 12'(drv_cyc - 18);
         end
      3: begin
           bus.i_strobe    = 1'b1;
           bus.i_inst_data = 12'd4095;
         end
      default: ;
    endcase
  end

  // Monitor: scoreboard pops on handshake plus hold, reset, idle and timeout checks.
  logic        pv_valid = 1'b0, pv_ready = 1'b0, pv_hs = 1'b0, rst_d = 1'b0;
  logic [1:0]  pv_chan = 2'd0, pv_mux = 2'd0;
  logic [11:0] pv_data = 12'd0;
  int          to_seen = 0;
  bit          fin_done = 1'b0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst_d) begin
      n_cmp++;
      if (bus.o_valid || bus.o_chan != 2'd0 || bus.o_avg_data != 12'd0 || mux_sel != 2'd0 || busy) begin
        n_err++;
        $display("FAIL reset_state: valid=%0b chan=%0d data=%0d mux=%0d busy=%0b, expected all zero",
                 bus.o_valid, bus.o_chan, bus.o_avg_data, mux_sel, busy);
      end
    end
    if (!rst) begin
      if (pv_valid && !pv_ready && !rst_d) begin
        n_cmp++;
        if (!bus.o_valid || bus.o_chan != pv_chan || bus.o_avg_data != pv_data || mux_sel != pv_mux) begin
          n_err++;
          $display("FAIL hold: valid=%0b chan=%0d data=%0d mux=%0d, expected valid=1 chan=%0d data=%0d mux=%0d",
                   bus.o_valid, bus.o_chan, bus.o_avg_data, mux_sel, pv_chan, pv_data, pv_mux);
        end
      end
      if (pv_hs) begin
        n_cmp++;
        if (bus.o_valid) begin
          n_err++;
          $display("FAIL single_xfer: valid=%0b after handshake, expected 0", bus.o_valid);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: chan=%0d data=%0d, expected no result", bus.o_chan, bus.o_avg_data);
        end else begin
          mon_e = q.pop_front();
          if (bus.o_chan != mon_e.ch || bus.o_avg_data != mon_e.val || mux_sel != mon_e.ch) begin
            n_err++;
            $display("FAIL result: chan=%0d data=%0d mux=%0d, expected chan=%0d data=%0d mux=%0d",
                     bus.o_chan, bus.o_avg_data, mux_sel, mon_e.ch, mon_e.val, mon_e.ch);
          end
        end
      end
    end
    if (busy_chk) begin
      n_cmp++;
      if (busy != busy_exp) begin
        n_err++;
        $display("FAIL busy: got %0b, expected %0b", busy, busy_exp);
      end
    end
    if (to_cnt != to_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d wait(s) expired, expected none", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    if (fin_req && !fin_done) begin
      n_cmp++;
      if (q.size() != 0) begin
        n_err++;
        $display("FAIL leftover: %0d results never delivered, expected 0", q.size());
      end
      fin_done = 1'b1;
    end
    pv_valid = bus.o_valid;
    pv_ready = bus.i_ready;
    pv_hs    = bus.o_valid && bus.i_ready && !rst;
    pv_chan  = bus.o_chan;
    pv_data  = bus.o_avg_data;
    pv_mux   = mux_sel;
    rst_d    = rst;
  end

  function automatic void push(input int ch, input int v);
    exp_t e;
    e.ch  = 2'(ch);
    e.val = 12'(v);
    q.push_back(e);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    gen_mode = 0;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (q.size() != 0 && k < max) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      to_cnt++;
      q.delete();
    end
    #1;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!bus.o_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!bus.o_valid) to_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mux(input logic [1:0] ch, input int max);
    int k = 0;
    while (mux_sel != ch && k < max) begin
      @(negedge clk);
      k++;
    end
    if (mux_sel != ch) to_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_ready = 1'b1;
    do_reset();

    // Full scan, constant per-channel samples.
    mask = 4'b1111; enable = 1'b1; gen_mode = 1;
    push(0, 100); push(1, 200); push(2, 300); push(3, 400); push(0, 100);
    wait_drain(2000);
    enable = 1'b0;
    cycles(4);
    busy_exp = 1'b0; busy_chk = 1'b1;
    cycles(5);
    busy_chk = 1'b0;

    // Sparse mask 1010.
    do_reset();
    mask = 4'b1010; enable = 1'b1; gen_mode = 1;
    push(1, 200); push(3, 400); push(1, 200); push(3, 400);
    wait_drain(2000);
    enable = 1'b0;
    cycles(4);

    // Ramp 0..7 after garbage during settle, then all-4095 with reselection.
    do_reset();
    mask = 4'b0001; enable = 1'b1; gen_mode = 2;
    push(0, 3);
    wait_drain(200);
    enable = 1'b0;
    cycles(4);
    gen_mode = 3; enable = 1'b1;
    push(0, 4095); push(0, 4095);
    wait_drain(400);
    enable = 1'b0;
    cycles(4);

    // Backpressure for 50 cycles.
    do_reset();
    mask = 4'b1111; bus.i_ready = 1'b0; enable = 1'b1; gen_mode = 1;
    push(0, 100); push(1, 200);
    wait_valid(500);
    cycles(50);
    bus.i_ready = 1'b1;
    wait_drain(500);
    enable = 1'b0;
    cycles(4);

    // Enable dropped during ch2 accumulation, then empty mask.
    do_reset();
    mask = 4'b1111; enable = 1'b1; gen_mode = 1;
    push(0, 100); push(1, 200); push(2, 300);
    wait_mux(2'd2, 500);
    cycles(25);
    enable = 1'b0;
    wait_drain(500);
    cycles(3);
    busy_exp = 1'b0; busy_chk = 1'b1;
    cycles(5);
    mask = 4'b0000; enable = 1'b1;
    cycles(10);
    busy_chk = 1'b0; enable = 1'b0;

    // Reset during ACCUM, reset during OUTPUT, then a clean rerun from ch0.
    do_reset();
    mask = 4'b1111; enable = 1'b1; gen_mode = 1;
    cycles(30);
    rst = 1'b1; enable = 1'b0; gen_mode = 0;
    cycles(2);
    rst = 1'b0;
    enable = 1'b1; gen_mode = 1; bus.i_ready = 1'b0;
    wait_valid(500);
    rst = 1'b1; bus.i_ready = 1'b1; enable = 1'b0; gen_mode = 0;
    cycles(2);
    rst = 1'b0;
    enable = 1'b1; gen_mode = 1;
    push(0, 100); push(1, 200); push(2, 300); push(3, 400); push(0, 100);
    wait_drain(2000);
    enable = 1'b0;
    cycles(4);

    fin_req = 1'b1;
    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
